// File: rtl/e203_exu_bjp_cmt_resolver.sv
// e203_exu_bjp_cmt_resolver
// Commit-side consumer of the branch/jump commit interface. Decides whether a
// committed BJP/MRET/DRET/FENCE.I needs a front-end redirect, registers the
// redirect target and holds the flush request until the IFU acknowledges it.
// Also keeps a saturating branch-misprediction counter.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where both
// valid and ready are high. A producer holds its payload stable while valid is
// high and ready is low. cmt_i_ready depends only on the FSM state;
// flush_o_valid/pc/cause stay stable until flush_o_ready is seen high.
module e203_exu_bjp_cmt_resolver #(
  parameter int PC_SIZE = 32,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmt_i_valid,
  output logic               cmt_i_ready,
  input  logic               cmt_i_bjp,
  input  logic               cmt_i_jalr,
  input  logic               cmt_i_mret,
  input  logic               cmt_i_dret,
  input  logic               cmt_i_fencei,
  input  logic               cmt_i_prdt,
  input  logic               cmt_i_rslv,
  input  logic               cmt_i_rv32,
  input  logic [PC_SIZE-1:0] cmt_i_pc,
  input  logic [XLEN-1:0]    cmt_i_imm,
  input  logic [XLEN-1:0]    cmt_i_rs1,
  input  logic [PC_SIZE-1:0] csr_mepc,
  input  logic [PC_SIZE-1:0] csr_dpc,
  output logic               flush_o_valid,
  input  logic               flush_o_ready,
  output logic [PC_SIZE-1:0] flush_o_pc,
  output logic [1:0]         flush_o_cause,
  output logic [CNT_W-1:0]   mispred_cnt,
  input  logic               mispred_cnt_clr
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [1:0] CAUSE_MISPRED = 2'b00;
  localparam logic [1:0] CAUSE_MRET    = 2'b01;
  localparam logic [1:0] CAUSE_DRET    = 2'b10;
  localparam logic [1:0] CAUSE_FENCEI  = 2'b11;

  state_t state;

  logic               accept;
  logic               mispred;
  logic               need_flush;
  logic [PC_SIZE-1:0] len;
  logic [PC_SIZE-1:0] imm_pc;
  logic [PC_SIZE-1:0] rs1_pc;
  logic [PC_SIZE-1:0] seq_pc;
  logic [PC_SIZE-1:0] br_sum;
  logic [PC_SIZE-1:0] br_pc;
  logic [PC_SIZE-1:0] tgt_pc;
  logic [1:0]         tgt_cause;

  assign cmt_i_ready = (state == IDLE);
  assign accept      = cmt_i_valid & cmt_i_ready;

  assign mispred    = cmt_i_bjp & (cmt_i_prdt != cmt_i_rslv);
  assign need_flush = mispred | cmt_i_mret | cmt_i_dret | cmt_i_fencei;

  // Offsets are truncated or zero-extended to the PC width; sums wrap silently.
  assign len    = cmt_i_rv32 ? PC_SIZE'(4) : PC_SIZE'(2);
  assign imm_pc = PC_SIZE'(cmt_i_imm);
  assign rs1_pc = PC_SIZE'(cmt_i_rs1);
  assign seq_pc = cmt_i_pc + len;
  assign br_sum = (cmt_i_jalr ? rs1_pc : cmt_i_pc) + imm_pc;
  // JALR targets always have bit 0 cleared.
  assign br_pc  = {br_sum[PC_SIZE-1:1], br_sum[0] & ~cmt_i_jalr};

  // Redirect target selection, priority mret > dret > fence.i > branch.
  always_comb begin
    tgt_pc    = seq_pc;
    tgt_cause = CAUSE_MISPRED;
    if (cmt_i_mret) begin
      tgt_pc    = csr_mepc;
      tgt_cause = CAUSE_MRET;
    end else if (cmt_i_dret) begin
      tgt_pc    = csr_dpc;
      tgt_cause = CAUSE_DRET;
    end else if (cmt_i_fencei) begin
      tgt_pc    = seq_pc;
      tgt_cause = CAUSE_FENCEI;
    end else if (cmt_i_rslv) begin
      tgt_pc    = br_pc;
      tgt_cause = CAUSE_MISPRED;
    end
  end

  // Flush FSM: capture target on a flushing accept, hold until acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      flush_o_valid <= 1'b0;
      flush_o_pc    <= '0;
      flush_o_cause <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept && need_flush) begin
            state         <= FLUSH;
            flush_o_valid <= 1'b1;
            flush_o_pc    <= tgt_pc;
            flush_o_cause <= tgt_cause;
          end
        end
        FLUSH: begin
          if (flush_o_valid && flush_o_ready) begin
            state         <= IDLE;
            flush_o_valid <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          flush_o_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating misprediction counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_cnt <= '0;
    end else if (mispred_cnt_clr) begin
      mispred_cnt <= '0;
    end else if (accept && mispred && (mispred_cnt != {CNT_W{1'b1}})) begin
      mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_e203_exu_bjp_cmt_resolver.sv
// Testbench for e203_exu_bjp_cmt_resolver. Expected redirects are pushed to a
// queue when a commit is driven and popped when the flush request appears.
// The counter is narrowed to 4 bits so saturation is reachable.
module tb_e203_exu_bjp_cmt_resolver;

  localparam int PC_SIZE = 32;
  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               cmt_i_valid, cmt_i_ready;
  logic               cmt_i_bjp, cmt_i_jalr, cmt_i_mret, cmt_i_dret, cmt_i_fencei;
  logic               cmt_i_prdt, cmt_i_rslv, cmt_i_rv32;
  logic [PC_SIZE-1:0] cmt_i_pc;
  logic [XLEN-1:0]    cmt_i_imm, cmt_i_rs1;
  logic [PC_SIZE-1:0] csr_mepc, csr_dpc;
  logic               flush_o_valid, flush_o_ready;
  logic [PC_SIZE-1:0] flush_o_pc;
  logic [1:0]         flush_o_cause;
  logic [CNT_W-1:0]   mispred_cnt;
  logic               mispred_cnt_clr;

  e203_exu_bjp_cmt_resolver #(
    .PC_SIZE(PC_SIZE),
    .XLEN   (XLEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmt_i_valid    (cmt_i_valid),
    .cmt_i_ready    (cmt_i_ready),
    .cmt_i_bjp      (cmt_i_bjp),
    .cmt_i_jalr     (cmt_i_jalr),
    .cmt_i_mret     (cmt_i_mret),
    .cmt_i_dret     (cmt_i_dret),
    .cmt_i_fencei   (cmt_i_fencei),
    .cmt_i_prdt     (cmt_i_prdt),
    .cmt_i_rslv     (cmt_i_rslv),
    .cmt_i_rv32     (cmt_i_rv32),
    .cmt_i_pc       (cmt_i_pc),
    .cmt_i_imm      (cmt_i_imm),
    .cmt_i_rs1      (cmt_i_rs1),
    .csr_mepc       (csr_mepc),
    .csr_dpc        (csr_dpc),
    .flush_o_valid  (flush_o_valid),
    .flush_o_ready  (flush_o_ready),
    .flush_o_pc     (flush_o_pc),
    .flush_o_cause  (flush_o_cause),
    .mispred_cnt    (mispred_cnt),
    .mispred_cnt_clr(mispred_cnt_clr)
  );

  // ---------------- scoreboard ----------------
  logic [33:0]      exp_q[$];   // {cause, pc}
  logic [CNT_W-1:0] exp_cnt;
  int               n_checks = 0;
  int               n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Drives one commit for one cycle, updates the model, checks the cycle after.
  task automatic send(input logic bjp, jalr, mret, dret, fencei, prdt, rslv, rv32,
                      input logic [31:0] pc, imm, rs1);
    logic [31:0] len, t;
    logic [1:0]  c;
    logic        mis, need;
    cmt_i_bjp = bjp;  cmt_i_jalr = jalr; cmt_i_mret = mret; cmt_i_dret = dret;
    cmt_i_fencei = fencei; cmt_i_prdt = prdt; cmt_i_rslv = rslv; cmt_i_rv32 = rv32;
    cmt_i_pc = pc; cmt_i_imm = imm; cmt_i_rs1 = rs1;
    cmt_i_valid = 1'b1;
    check("ready_before_accept", cmt_i_ready, 1);
    len  = rv32 ? 32'd4 : 32'd2;
    mis  = bjp && (prdt != rslv);
    need = mis || mret || dret || fencei;
    c    = 2'b00;
    if (mret)        begin t = csr_mepc; c = 2'b01; end
    else if (dret)   begin t = csr_dpc;  c = 2'b10; end
    else if (fencei) begin t = pc + len; c = 2'b11; end
    else if (rslv)   begin t = (jalr ? rs1 : pc) + imm; if (jalr) t[0] = 1'b0; end
    else                   t = pc + len;
    if (mispred_cnt_clr) exp_cnt = '0;
    else if (mis && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    if (need) exp_q.push_back({c, t});
    @(posedge clk); #1;
    cmt_i_valid = 1'b0;
    mispred_cnt_clr = 1'b0;
    check("flush_valid_after_accept", flush_o_valid, need);
    check("cnt_after_accept", mispred_cnt, exp_cnt);
  endtask

  // Checks the pending redirect, stalls the IFU for 'hold' cycles while a
  // blocked mispredict commit is offered, then completes the handshake.
  task automatic wait_flush(input int hold, input logic clr_in_hold);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_nonempty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check("flush_pc", flush_o_pc, e[31:0]);
    check("flush_cause", flush_o_cause, e[33:32]);
    check("ready_in_flush", cmt_i_ready, 0);
    for (int i = 0; i < hold; i++) begin
      cmt_i_bjp = 1'b1; cmt_i_prdt = 1'b0; cmt_i_rslv = 1'b1;
      cmt_i_valid = 1'b1;
      if (clr_in_hold && i == 0) begin
        mispred_cnt_clr = 1'b1;
        exp_cnt = '0;
      end
      @(posedge clk); #1;
      cmt_i_valid = 1'b0;
      mispred_cnt_clr = 1'b0;
      check("hold_valid", flush_o_valid, 1);
      check("hold_pc", flush_o_pc, e[31:0]);
      check("hold_cause", flush_o_cause, e[33:32]);
      check("hold_ready", cmt_i_ready, 0);
      check("hold_cnt", mispred_cnt, exp_cnt);
    end
    flush_o_ready = 1'b1;
    @(posedge clk); #1;
    flush_o_ready = 1'b0;
    check("valid_after_ack", flush_o_valid, 0);
    check("ready_after_ack", cmt_i_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    cmt_i_valid = 0; cmt_i_bjp = 0; cmt_i_jalr = 0; cmt_i_mret = 0; cmt_i_dret = 0;
    cmt_i_fencei = 0; cmt_i_prdt = 0; cmt_i_rslv = 0; cmt_i_rv32 = 1;
    cmt_i_pc = '0; cmt_i_imm = '0; cmt_i_rs1 = '0;
    csr_mepc = '0; csr_dpc = '0; flush_o_ready = 0; mispred_cnt_clr = 0;
    exp_cnt = '0;
    #12;
    check("rst_ready", cmt_i_ready, 1);
    check("rst_valid", flush_o_valid, 0);
    check("rst_pc", flush_o_pc, 0);
    check("rst_cause", flush_o_cause, 0);
    check("rst_cnt", mispred_cnt, 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // correctly predicted BEQs back to back; stray flush_o_ready is ignored
    flush_o_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(1, 0, 0, 0, 0, 1, 1, 1, 32'h100 + 4 * i, 32'h20, 0);
    flush_o_ready = 1'b0;

    // mispredicted taken, IFU stalls 3 cycles
    send(1, 0, 0, 0, 0, 0, 1, 1, 32'h1000, 32'hFFFF_FFF0, 0);
    wait_flush(3, 0);
    // mispredicted not-taken 16-bit, wraps to 0
    send(1, 0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFE, 32'h40, 0);
    wait_flush(0, 0);
    // MRET beats a simultaneous mispredict
    csr_mepc = 32'h8000_0040;
    send(1, 0, 1, 0, 0, 0, 1, 1, 32'h300, 32'h8, 0);
    wait_flush(1, 0);
    // JALR mispredict, bit 0 cleared
    send(1, 1, 0, 0, 0, 0, 1, 1, 32'h500, 32'h4, 32'h2001);
    wait_flush(0, 0);
    // DRET and FENCE.I
    csr_dpc = 32'h0000_1234;
    send(0, 0, 0, 1, 0, 0, 0, 1, 32'h600, 0, 0);
    wait_flush(0, 0);
    send(0, 0, 0, 0, 1, 0, 0, 1, 32'h200, 0, 0);
    wait_flush(2, 0);

    // randomized commits
    for (int i = 0; i < 20; i++) begin
      logic [31:0] rpc;
      csr_mepc = $urandom(); csr_dpc = $urandom();
      rpc = $urandom() & 32'hFFFF_FFFE;
      send($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           rpc, $urandom(), $urandom());
      if (exp_q.size() != 0) wait_flush($urandom_range(0, 2), 0);
    end

    // saturation at all-ones
    for (int i = 0; i < 20 && exp_cnt != {CNT_W{1'b1}}; i++) begin
      send(1, 0, 0, 0, 0, 0, 1, 1, 32'h700, 32'h10, 0);
      wait_flush(0, 0);
    end
    send(1, 0, 0, 0, 0, 0, 1, 1, 32'h700, 32'h10, 0);
    check("cnt_saturated", mispred_cnt, 4'hF);
    wait_flush(0, 0);

    // clear coincident with a mispredict accept
    mispred_cnt_clr = 1'b1;
    send(1, 0, 0, 0, 0, 1, 0, 1, 32'h800, 0, 0);
    check("cnt_clr_wins", mispred_cnt, 0);
    wait_flush(0, 0);
    // clear while in FLUSH
    send(1, 0, 0, 0, 0, 0, 1, 1, 32'h900, 32'h100, 0);
    wait_flush(2, 1);

    // asynchronous reset mid-FLUSH
    send(1, 0, 0, 0, 0, 0, 1, 1, 32'hA00, 32'h100, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", flush_o_valid, 0);
    check("arst_pc", flush_o_pc, 0);
    check("arst_cause", flush_o_cause, 0);
    check("arst_cnt", mispred_cnt, 0);
    exp_q.delete();
    exp_cnt = '0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_arst", cmt_i_ready, 1);
    send(1, 0, 0, 0, 0, 1, 1, 1, 32'hB00, 0, 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/e203_exu_bjp_cmt_resolver.md
# e203_exu_bjp_cmt_resolver

Commit-side consumer of the branch/jump commit interface. It accepts one resolved BJP/MRET/DRET/FENCE.I commit per handshake and decides whether the front end must be redirected. It registers the redirect target and holds a flush request toward the IFU until that request is acknowledged. It also keeps a saturating branch-misprediction counter for performance monitoring.

## Interface
Parameters:
- PC_SIZE, 32, PC and target width
- XLEN, 32, immediate/rs1 width
- CNT_W, 32, misprediction counter width

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; asynchronous, active-low
- cmt_i_valid  in  1  commit valid
- cmt_i_ready  out  1  commit ready
- cmt_i_bjp  in  1  conditional branch or jump
- cmt_i_jalr  in  1  JALR; taken target is rs1+imm
- cmt_i_mret  in  1  MRET commit
- cmt_i_dret  in  1  DRET commit
- cmt_i_fencei  in  1  FENCE.I commit
- cmt_i_prdt  in  1  predicted taken
- cmt_i_rslv  in  1  resolved taken
- cmt_i_rv32  in  1  1 = 32-bit instruction, 0 = 16-bit
- cmt_i_pc  in  PC_SIZE  instruction PC
- cmt_i_imm  in  XLEN  branch/jump offset
- cmt_i_rs1  in  XLEN  JALR base
- csr_mepc  in  PC_SIZE  MRET return PC
- csr_dpc  in  PC_SIZE  DRET return PC
- flush_o_valid  out  1  redirect request
- flush_o_ready  in  1  IFU acknowledges redirect
- flush_o_pc  out  PC_SIZE  redirect target
- flush_o_cause  out  2  00 mispredict, 01 mret, 10 dret, 11 fence.i
- mispred_cnt  out  CNT_W  misprediction count
- mispred_cnt_clr  in  1  synchronous counter clear

## Operation
- FSM has two states: IDLE and FLUSH. Reset state is IDLE.
- cmt_i_ready = (state == IDLE). This is combinational from state only.
- A commit is accepted when cmt_i_valid & cmt_i_ready.
- Defined terms:
  - len = cmt_i_rv32 ? 4 : 2
  - mispred = cmt_i_bjp & (cmt_i_prdt != cmt_i_rslv)
- need_flush = mispred | cmt_i_mret | cmt_i_dret | cmt_i_fencei
- Target is selected in priority order mret > dret > fencei > bjp:
  - mret: csr_mepc, cause 01
  - dret: csr_dpc, cause 10
  - fencei: cmt_i_pc + len, cause 11
  - mispred & rslv: (cmt_i_jalr ? cmt_i_rs1 : cmt_i_pc) + cmt_i_imm, cause 00
  - mispred & !rslv: cmt_i_pc + len, cause 00
- All additions are modulo 2^PC_SIZE. Wrap-around is silent, with no error.
- imm and rs1 are truncated or zero-extended to PC_SIZE.
- For JALR targets, bit 0 is forced to 0.
- Accept with need_flush: register flush_o_pc and flush_o_cause, set flush_o_valid, go to FLUSH.
- Accept without need_flush: stay in IDLE. The commit is consumed in that cycle and has no other effect.
- In FLUSH:
  - flush_o_valid, flush_o_pc and flush_o_cause are held stable.
  - No new commit is accepted.
  - On flush_o_valid & flush_o_ready: clear flush_o_valid and return to IDLE.
- Counter:
  - Increments by 1 on each accepted commit with mispred.
  - Saturates at all-ones.
  - mispred_cnt_clr sets it to 0 and wins over a simultaneous increment.
  - The counter is independent of FSM state; clear is honoured in both states.
- Reset values:
  - state IDLE
  - flush_o_valid 0
  - flush_o_pc 0
  - flush_o_cause 00
  - mispred_cnt 0
- Asynchronous reset mid-FLUSH drops the pending request immediately, with no handshake.

## Timing
- Accept to flush_o_valid: 1 cycle, registered. Asserted the cycle after the accepting edge.
- Minimum FLUSH residency is 1 cycle. If flush_o_ready is high in the first FLUSH cycle, the block is back in IDLE one cycle later.
- cmt_i_ready returns high the cycle after the flush handshake. There is no same-cycle re-accept.
- Throughput:
  - Non-flushing commits: 1 per cycle.
  - Flushing commits: at most 1 per 2 cycles.
- The counter update is visible on mispred_cnt the cycle after the accept or clear.
- flush_o_ready while flush_o_valid is low is ignored.

## Test plan
- Correctly predicted BEQ (bjp=1, prdt=1, rslv=1, pc=0x100) -> no flush_o_valid, cmt_i_ready stays 1, mispred_cnt unchanged, back-to-back accepts every cycle.
- Mispredicted taken branch (prdt=0, rslv=1, pc=0x1000, imm=0xFFFFFFF0) -> next cycle flush_o_valid=1, flush_o_pc=0x0FF0, cause 00, mispred_cnt=1. With flush_o_ready held low for 3 cycles: outputs stable and cmt_i_ready=0 throughout.
- Mispredicted not-taken branch, 16-bit (rv32=0, prdt=1, rslv=0, pc=0xFFFFFFFE) -> flush_o_pc=0x00000000 (wrap), cause 00.
- MRET with mispred also asserted (mret=1, csr_mepc=0x80000040) -> flush_o_pc=0x80000040, cause 01. JALR mispredict with rs1=0x2001, imm=4 -> flush_o_pc=0x2004.
- Counter at 0xFFFFFFFF plus mispredict -> stays 0xFFFFFFFF. Clear coincident with a mispredict accept -> 0 next cycle.
- rst_n pulsed low while in FLUSH -> flush_o_valid=0, flush_o_pc=0, mispred_cnt=0 immediately; cmt_i_ready=1 after release.
